// File: rtl/svc_sram_rd_ctrl_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : svc_sram_rd_ctrl_if
// Purpose  : Groups the SRAM read command stream and the read response stream
//            of svc_sram_rd_ctrl.
// Signals  : sram_rd_cmd_valid/ready/addr - read command (valid/ready)
//            sram_resp_rd_valid/ready/data - read response (valid/ready)
// Modports : master - produces commands, consumes responses
//            slave  - consumes commands, produces responses (the controller)
// Revision : 1.0 - initial release
// ============================================================================
interface svc_sram_rd_ctrl_if #(
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 16
);
  logic                       sram_rd_cmd_valid;
  logic                       sram_rd_cmd_ready;
  logic [SRAM_ADDR_WIDTH-1:0] sram_rd_cmd_addr;
  logic                       sram_resp_rd_valid;
  logic                       sram_resp_rd_ready;
  logic [SRAM_DATA_WIDTH-1:0] sram_resp_rd_data;

  modport master (
    output sram_rd_cmd_valid, sram_rd_cmd_addr, sram_resp_rd_ready,
    input  sram_rd_cmd_ready, sram_resp_rd_valid, sram_resp_rd_data
  );

  modport slave (
    input  sram_rd_cmd_valid, sram_rd_cmd_addr, sram_resp_rd_ready,
    output sram_rd_cmd_ready, sram_resp_rd_valid, sram_resp_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/svc_sram_rd_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : svc_sram_rd_ctrl
// Purpose  : Drives the read pins of an external asynchronous SRAM. Each
//            accepted command holds its address on the pins for RD_WAIT
//            cycles, samples the data bus on the last edge and pushes it
//            into a small in-order response FIFO. Back-to-back commands are
//            chained without an idle gap on ce_n/oe_n.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            rd_if (slave)       - command stream in, response stream out
//            sram_io_addr_o      - registered SRAM address pins
//            sram_io_data_i      - SRAM data pins (read only)
//            sram_io_ce_n_o      - chip enable, active low, registered
//            sram_io_oe_n_o      - output enable, active low, registered
//            sram_io_we_n_o      - write enable, tied inactive
// Revision : 1.0 - initial release
// ============================================================================
module svc_sram_rd_ctrl #(
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int RD_WAIT         = 2,
  parameter int RESP_DEPTH      = 2
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  svc_sram_rd_ctrl_if.slave               rd_if,
  output logic [SRAM_ADDR_WIDTH-1:0]      sram_io_addr_o,
  input  wire logic [SRAM_DATA_WIDTH-1:0] sram_io_data_i,
  output logic                            sram_io_ce_n_o,
  output logic                            sram_io_oe_n_o,
  output logic                            sram_io_we_n_o
);

  localparam int CNT_W  = $clog2(RD_WAIT + 1);
  localparam int FCNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W  = $clog2(RESP_DEPTH);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [FCNT_W:0]   DEPTH_EXT = (FCNT_W + 1)'(RESP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic                       ce_n_q;
  logic                       oe_n_q;
  logic                       live_q;   // low until the first edge after reset release

  logic [SRAM_DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [FCNT_W-1:0]          fifo_cnt_q;
  logic [FCNT_W-1:0]          fifo_cnt_d;

  // --------------------------------------------------------------------------
  // Credit / handshake logic
  // --------------------------------------------------------------------------
  logic             last_cyc;
  logic             inflight;
  logic             push;
  logic             pop;
  logic             space;
  logic             cmd_ready;
  logic             cmd_fire;
  logic [FCNT_W:0]  occupancy;

  assign inflight = (state_q == ST_ACCESS);
  assign last_cyc = inflight && (cnt_q == CNT_ONE);
  assign push     = last_cyc;
  assign pop      = rd_if.sram_resp_rd_valid && rd_if.sram_resp_rd_ready;

  // Slots committed after this edge: stored words plus the read in progress,
  // minus the word leaving now. pop implies fifo_cnt_q >= 1, so no underflow.
  // The pop term deliberately gives a combinational ready->ready path so a
  // full FIFO can accept a new command in the same cycle it is drained.
  assign occupancy = {1'b0, fifo_cnt_q}
                   + {{FCNT_W{1'b0}}, inflight}
                   - {{FCNT_W{1'b0}}, pop};
  assign space     = (occupancy < DEPTH_EXT);

  assign cmd_ready = live_q && space && ((state_q == ST_IDLE) || last_cyc);
  assign cmd_fire  = rd_if.sram_rd_cmd_valid && cmd_ready;

  // --------------------------------------------------------------------------
  // Access FSM with registered pin outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (cmd_fire) begin
        // Fresh start from IDLE or a chained reload on the last access cycle;
        // ce_n/oe_n remain asserted across the chain.
        state_q <= ST_ACCESS;
        cnt_q   <= CNT_LOAD;
        addr_q  <= rd_if.sram_rd_cmd_addr;
        ce_n_q  <= 1'b0;
        oe_n_q  <= 1'b0;
      end else if (last_cyc) begin
        // Address pins keep their last value while idle.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        ce_n_q  <= 1'b1;
        oe_n_q  <= 1'b1;
      end else if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + FCNT_ONE;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - FCNT_ONE;
    end
  end

  // Storage is cleared on reset so the response data bus reads zero while
  // the FIFO is empty after reset. Pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= sram_io_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_if.sram_rd_cmd_ready  = cmd_ready;
  assign rd_if.sram_resp_rd_valid = (fifo_cnt_q != '0);
  assign rd_if.sram_resp_rd_data  = mem_q[rd_ptr_q];

  assign sram_io_addr_o = addr_q;
  assign sram_io_ce_n_o = ce_n_q;
  assign sram_io_oe_n_o = oe_n_q;
  assign sram_io_we_n_o = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_svc_sram_rd_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_svc_sram_rd_ctrl
// Purpose  : Self-checking bench for svc_sram_rd_ctrl. Two instances share
//            clock and reset: u_dut_a (RD_WAIT=2) and u_dut_b (RD_WAIT=1).
//            Each drives a behavioural SRAM whose data is a fixed function
//            of the address; responses are compared against an in-order
//            queue of expected words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svc_sram_rd_ctrl;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int DEPTH = 2;
  localparam int NRND  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural SRAM contents: fixed function of the address.
  function automatic logic [DW-1:0] sram_fn(input logic [AW-1:0] a);
    if (a == 20'h0A000) return 16'hD000;
    if (a < 20'd4)      return 16'h1111 * (a[15:0] + 16'd1);
    return a[15:0] ^ 16'h5A3C ^ {12'h000, a[19:16]};
  endfunction

  svc_sram_rd_ctrl_if #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) if_a ();
  svc_sram_rd_ctrl_if #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) if_b ();

  logic [AW-1:0] pin_addr_a, pin_addr_b;
  logic [DW-1:0] pin_data_a, pin_data_b;
  logic          ce_a, oe_a, we_a, ce_b, oe_b, we_b;

  assign pin_data_a = sram_fn(pin_addr_a);
  assign pin_data_b = sram_fn(pin_addr_b);

  svc_sram_rd_ctrl #(
    .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .RD_WAIT(2), .RESP_DEPTH(DEPTH)
  ) u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_if          (if_a),
    .sram_io_addr_o (pin_addr_a),
    .sram_io_data_i (pin_data_a),
    .sram_io_ce_n_o (ce_a),
    .sram_io_oe_n_o (oe_a),
    .sram_io_we_n_o (we_a)
  );

  svc_sram_rd_ctrl #(
    .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .RD_WAIT(1), .RESP_DEPTH(DEPTH)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_if          (if_b),
    .sram_io_addr_o (pin_addr_b),
    .sram_io_data_i (pin_data_b),
    .sram_io_ce_n_o (ce_b),
    .sram_io_oe_n_o (oe_b),
    .sram_io_we_n_o (we_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q_exp [$];
  logic [AW-1:0] bp_addr [3];
  int            nacc, npop, nce;
  int            first_acc, last_acc, first_ce, last_ce, first_r, last_r;
  int            max_out;
  logic          hold_prev, pend;
  logic [DW-1:0] hold_data;

  initial begin
    bp_addr[0] = 20'h12345;
    bp_addr[1] = 20'h54321;
    bp_addr[2] = 20'hABCDE;

    if_a.sram_rd_cmd_valid  = 1'b0;
    if_a.sram_rd_cmd_addr   = '0;
    if_a.sram_resp_rd_ready = 1'b0;
    if_b.sram_rd_cmd_valid  = 1'b0;
    if_b.sram_rd_cmd_addr   = '0;
    if_b.sram_resp_rd_ready = 1'b0;

    // ---------------- Reset ----------------
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ce_n",   32'(ce_a), 32'd1);
    chk("rst_oe_n",   32'(oe_a), 32'd1);
    chk("rst_we_n",   32'(we_a), 32'd1);
    chk("rst_addr",   32'(pin_addr_a), 32'd0);
    chk("rst_rvalid", 32'(if_a.sram_resp_rd_valid), 32'd0);
    chk("rst_rdata",  32'(if_a.sram_resp_rd_data), 32'd0);
    chk("rst_cready", 32'(if_a.sram_rd_cmd_ready), 32'd0);
    chk("rst_b_ce_n", 32'(ce_b), 32'd1);
    chk("rst_b_we_n", 32'(we_b), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(if_a.sram_rd_cmd_ready), 32'd0);
    cyc();
    #1;
    chk("rdy_after_edge",   32'(if_a.sram_rd_cmd_ready), 32'd1);
    chk("rdy_b_after_edge", 32'(if_b.sram_rd_cmd_ready), 32'd1);

    // ---------------- Single read, RD_WAIT=2 ----------------
    if_a.sram_resp_rd_ready = 1'b1;
    if_a.sram_rd_cmd_valid  = 1'b1;
    if_a.sram_rd_cmd_addr   = 20'h0A000;
    #1;
    chk("single_accept", 32'(if_a.sram_rd_cmd_ready), 32'd1);
    cyc();
    if_a.sram_rd_cmd_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("single_ce_n",   32'(ce_a), 32'd0);
      chk("single_oe_n",   32'(oe_a), 32'd0);
      chk("single_addr",   32'(pin_addr_a), 32'h0A000);
      chk("single_early_valid", 32'(if_a.sram_resp_rd_valid), 32'd0);
      cyc();
      #1;
    end
    chk("single_valid",    32'(if_a.sram_resp_rd_valid), 32'd1);
    chk("single_data",     32'(if_a.sram_resp_rd_data), 32'hD000);
    chk("single_ce_idle",  32'(ce_a), 32'd1);
    chk("single_oe_idle",  32'(oe_a), 32'd1);
    cyc();
    #1;
    chk("single_one_cycle", 32'(if_a.sram_resp_rd_valid), 32'd0);

    // ---------------- Back-to-back, RD_WAIT=1 ----------------
    if_b.sram_resp_rd_ready = 1'b1;
    q_exp.delete();
    nacc = 0; npop = 0; nce = 0;
    first_acc = -1; last_acc = -1; first_ce = -1; last_ce = -1; first_r = -1; last_r = -1;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if_b.sram_rd_cmd_valid = (nacc < 4);
      if_b.sram_rd_cmd_addr  = AW'(nacc);
      #1;
      if (!ce_b) begin
        nce++;
        if (first_ce < 0) first_ce = c;
        last_ce = c;
      end
      if (if_b.sram_resp_rd_valid && if_b.sram_resp_rd_ready) begin
        if (q_exp.size() == 0) chk("b2b_spurious", 32'd1, 32'd0);
        else chk("b2b_data", 32'(if_b.sram_resp_rd_data), 32'(q_exp.pop_front()));
        npop++;
        if (first_r < 0) first_r = c;
        last_r = c;
      end
      if (if_b.sram_rd_cmd_valid && if_b.sram_rd_cmd_ready) begin
        q_exp.push_back(sram_fn(if_b.sram_rd_cmd_addr));
        nacc++;
        if (first_acc < 0) first_acc = c;
        last_acc = c;
      end
    end
    if_b.sram_rd_cmd_valid = 1'b0;
    chk("b2b_accepts",  32'(nacc), 32'd4);
    chk("b2b_acc_span", 32'(last_acc - first_acc), 32'd3);
    chk("b2b_ce_cycles", 32'(nce), 32'd4);
    chk("b2b_ce_span",  32'(last_ce - first_ce), 32'd3);
    chk("b2b_resps",    32'(npop), 32'd4);
    chk("b2b_resp_span", 32'(last_r - first_r), 32'd3);

    // ---------------- Backpressure, RD_WAIT=2, DEPTH=2 ----------------
    cyc();
    if_a.sram_resp_rd_ready = 1'b0;
    q_exp.delete();
    nacc = 0; npop = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if_a.sram_rd_cmd_valid = (nacc < 3);
      if_a.sram_rd_cmd_addr  = (nacc < 3) ? bp_addr[nacc] : '0;
      #1;
      if (if_a.sram_rd_cmd_valid && if_a.sram_rd_cmd_ready) begin
        q_exp.push_back(sram_fn(if_a.sram_rd_cmd_addr));
        nacc++;
      end
      if (c >= 8) begin
        chk("bp_hold_valid", 32'(if_a.sram_resp_rd_valid), 32'd1);
        chk("bp_hold_data",  32'(if_a.sram_resp_rd_data), 32'(sram_fn(bp_addr[0])));
      end
    end
    chk("bp_accepts",   32'(nacc), 32'd2);
    chk("bp_ready_low", 32'(if_a.sram_rd_cmd_ready), 32'd0);
    cyc();
    if_a.sram_resp_rd_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", 32'(if_a.sram_rd_cmd_ready), 32'd1);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        cyc();
        if_a.sram_rd_cmd_valid = (nacc < 3);
        if_a.sram_rd_cmd_addr  = (nacc < 3) ? bp_addr[nacc] : '0;
        #1;
      end
      if (if_a.sram_resp_rd_valid && if_a.sram_resp_rd_ready) begin
        if (q_exp.size() == 0) chk("bp_spurious", 32'd1, 32'd0);
        else chk("bp_order", 32'(if_a.sram_resp_rd_data), 32'(q_exp.pop_front()));
        npop++;
      end
      if (if_a.sram_rd_cmd_valid && if_a.sram_rd_cmd_ready) begin
        q_exp.push_back(sram_fn(if_a.sram_rd_cmd_addr));
        nacc++;
      end
    end
    if_a.sram_rd_cmd_valid = 1'b0;
    chk("bp_total_acc", 32'(nacc), 32'd3);
    chk("bp_total_pop", 32'(npop), 32'd3);

    // ---------------- Reset during ACCESS ----------------
    cyc();
    if_a.sram_rd_cmd_valid = 1'b1;
    if_a.sram_rd_cmd_addr  = 20'h0BEEF;
    #1;
    chk("rst_mid_accept", 32'(if_a.sram_rd_cmd_ready), 32'd1);
    cyc();
    if_a.sram_rd_cmd_valid = 1'b0;
    #1;
    chk("rst_mid_pre_ce", 32'(ce_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ce_n",   32'(ce_a), 32'd1);
    chk("rst_mid_oe_n",   32'(oe_a), 32'd1);
    chk("rst_mid_rvalid", 32'(if_a.sram_resp_rd_valid), 32'd0);
    chk("rst_mid_addr",   32'(pin_addr_a), 32'd0);
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      #1;
      chk("rst_no_stale", 32'(if_a.sram_resp_rd_valid), 32'd0);
    end

    // ---------------- Random traffic on RD_WAIT=2 ----------------
    q_exp.delete();
    nacc = 0; max_out = 0; hold_prev = 1'b0; pend = 1'b0; hold_data = '0;
    for (int c = 0; c < 20000 && (nacc < NRND || q_exp.size() > 0); c++) begin
      cyc();
      if (!pend) begin
        if_a.sram_rd_cmd_valid = (nacc < NRND) && ($urandom_range(99, 0) < 70);
        if_a.sram_rd_cmd_addr  = AW'($urandom);
      end
      if_a.sram_resp_rd_ready = (nacc >= NRND) || ($urandom_range(99, 0) < 60);
      #1;
      if (hold_prev) begin
        chk("rnd_valid_stable", 32'(if_a.sram_resp_rd_valid), 32'd1);
        chk("rnd_data_stable",  32'(if_a.sram_resp_rd_data), 32'(hold_data));
      end
      if (if_a.sram_resp_rd_valid && if_a.sram_resp_rd_ready) begin
        if (q_exp.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
        else chk("rnd_data", 32'(if_a.sram_resp_rd_data), 32'(q_exp.pop_front()));
      end
      if (if_a.sram_rd_cmd_valid && if_a.sram_rd_cmd_ready) begin
        q_exp.push_back(sram_fn(if_a.sram_rd_cmd_addr));
        nacc++;
      end
      if (q_exp.size() > max_out) max_out = q_exp.size();
      pend      = if_a.sram_rd_cmd_valid && !if_a.sram_rd_cmd_ready;
      hold_prev = if_a.sram_resp_rd_valid && !if_a.sram_resp_rd_ready;
      hold_data = if_a.sram_resp_rd_data;
    end
    if_a.sram_rd_cmd_valid = 1'b0;
    chk("rnd_cmds",    32'(nacc), 32'(NRND));
    chk("rnd_drained", 32'(q_exp.size()), 32'd0);
    chk("rnd_credit_le_depth", 32'(max_out <= DEPTH), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/svc_sram_rd_ctrl.md
Name: svc_sram_rd_ctrl

Overview:
Downstream of the AXI-lite to SRAM read adapter. Consumes its sram_rd_cmd valid/ready stream and drives an external asynchronous SRAM through its read pins. Holds each address for a fixed number of wait cycles, then samples the data. Returns data in order on the sram_resp_rd valid/ready stream through a small response FIFO.

Parameters:
SRAM_ADDR_WIDTH, 20, word address width; matches upstream sram_rd_cmd_addr.
SRAM_DATA_WIDTH, 16, data word width.
RD_WAIT, 2, cycles each address is held on the pins before sampling. Must be at least 1.
RESP_DEPTH, 2, response FIFO entries. Power of two, at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sram_rd_cmd_valid  in  1  read command valid
sram_rd_cmd_ready  out  1  command accepted when valid and ready are both high
sram_rd_cmd_addr  in  SRAM_ADDR_WIDTH  word address
sram_resp_rd_valid  out  1  response valid
sram_resp_rd_ready  in  1  response consumed when valid and ready are both high
sram_resp_rd_data  out  SRAM_DATA_WIDTH  read data
sram_io_addr  out  SRAM_ADDR_WIDTH  registered SRAM address pins
sram_io_data  in  SRAM_DATA_WIDTH  SRAM data pins (input only)
sram_io_ce_n  out  1  chip enable, active low, registered
sram_io_oe_n  out  1  output enable, active low, registered
sram_io_we_n  out  1  write enable; constant 1

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; wait counter 0; FIFO empty.
  - sram_io_addr=0, sram_io_ce_n=1, sram_io_oe_n=1, sram_io_we_n=1.
  - sram_resp_rd_valid=0, sram_resp_rd_data=0, sram_rd_cmd_ready=0.
- States: IDLE, ACCESS.
- Credits:
  - inflight = 1 while in ACCESS.
  - pop = sram_resp_rd_valid & sram_resp_rd_ready.
  - space = (fifo_count + inflight - pop) < RESP_DEPTH.
  - The combinational path from sram_resp_rd_ready to sram_rd_cmd_ready is intentional.
- sram_rd_cmd_ready is high when space is true and either:
  - state is IDLE, or
  - state is ACCESS and wait counter == 1 (last cycle of the access).
  - It is low out of reset until the first clock edge after rst_n is released.
- Command accept at edge E:
  - sram_io_addr <= cmd_addr; ce_n <= 0; oe_n <= 0.
  - Counter <= RD_WAIT; state <= ACCESS.
- In ACCESS: the counter decrements each edge. At the edge where the counter equals 1:
  - sram_io_data is written into the FIFO tail.
  - If a new command is accepted on the same edge: reload address and counter, stay in ACCESS, ce_n/oe_n stay 0 (no idle gap).
  - Otherwise: state <= IDLE, ce_n <= 1, oe_n <= 1. sram_io_addr holds its last value.
- Timing:
  - The address is stable on the pins for exactly RD_WAIT cycles. Data is sampled at edge E+RD_WAIT.
  - sram_resp_rd_valid rises in the cycle after E+RD_WAIT when the FIFO was empty. Latency is RD_WAIT+1 cycles from accept to visible valid.
  - Peak throughput is one read per RD_WAIT cycles.
- FIFO:
  - Registered outputs; in-order (first in, first out).
  - Push and pop on the same edge are both honoured, and count is unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - The credit scheme makes push-when-full impossible; the bench asserts it never happens.
  - sram_resp_rd_data is stable while valid is high and ready is low.
  - sram_resp_rd_valid and sram_resp_rd_data stay stable until consumed (AXI-style stability).
- Reset mid-access: the in-flight read is discarded, FIFO contents are discarded, pins return to idle immediately.
- Width rules:
  - Counter width is $clog2(RD_WAIT+1).
  - FIFO count width is $clog2(RESP_DEPTH+1).
  - No arithmetic is performed on addresses.

Test Plan:
- Reset: hold rst_n=0, then release → ce_n=oe_n=we_n=1, sram_io_addr=0, resp_valid=0. Then cmd_ready=1 from the first edge after release.
- Single read, RD_WAIT=2, resp_ready held 1:
  - Accept addr 0x0A000 at edge E0. Bench models SRAM returning 0xD000.
  - Required: ce_n/oe_n=0 and sram_io_addr=0x0A000 during E0..E0+2.
  - Required: resp_valid=1 with data 0xD000 for exactly one cycle after E0+2. Then ce_n=oe_n=1.
- Back-to-back, RD_WAIT=1, resp_ready=1, four commands to addresses 0..3 with data 0x1111·(addr+1):
  - Required: one accept per cycle; ce_n stays low with no gaps.
  - Required: responses 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
- Backpressure, RESP_DEPTH=2, resp_ready=0:
  - Issue three commands. Required: two accepted; cmd_ready=0 with the third command pending; data held stable.
  - Raise resp_ready. Required: the third command is accepted in the cycle of the first pop; all three responses arrive in order.
- Reset during ACCESS: drop rst_n mid-wait → ce_n=oe_n=1 and resp_valid=0 without waiting for a clock edge. No stale response appears after release.
- Random traffic (1000 commands, random valid/ready) → responses match the address-derived data in order. Scoreboard: pushes never exceed RESP_DEPTH.
